// File: rtl/sm_conv_arbiter.sv
// Two-requester round-robin front end for a shared sign-magnitude to two's-complement converter.
// Optional `SM_CONV_ARB_NEGZERO_EN adds io_out_negzero, flagging results produced from sign=1, mag=0.
module sm_conv_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in0_valid,
    output logic             io_in0_ready,
    input  logic             io_in0_sign,
    input  logic [WIDTH-1:0] io_in0_mag,
    input  logic             io_in1_valid,
    output logic             io_in1_ready,
    input  logic             io_in1_sign,
    input  logic [WIDTH-1:0] io_in1_mag,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH:0]   io_out_twos,
`ifdef SM_CONV_ARB_NEGZERO_EN
    output logic             io_out_negzero,
`endif
    output logic             io_out_src
);

    typedef enum logic { ST_EMPTY = 1'b0, ST_FULL = 1'b1 } state_e;

    state_e           state_q;
    logic             last_q;
    logic [WIDTH:0]   twos_q;
    logic             src_q;
    logic             can_load;
    logic             grant_vld;
    logic             grant;
    logic             accept;
    logic             sel_sign;
    logic [WIDTH-1:0] sel_mag;
    logic [WIDTH:0]   twos_d;

    // Valid/ready: a transfer happens on a port in any cycle where valid and ready are
    // both high; ready may depend on valid, but valid must never wait for ready.
    assign can_load = (state_q == ST_EMPTY) || io_out_ready;

    always_comb begin
        grant_vld = io_in0_valid || io_in1_valid;
        grant     = 1'b0;
        if (io_in0_valid && io_in1_valid) begin
            grant = ~last_q;
        end else if (io_in1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept       = grant_vld && can_load && !reset;
    assign io_in0_ready = accept && (grant == 1'b0);
    assign io_in1_ready = accept && (grant == 1'b1);

    assign sel_sign = grant ? io_in1_sign : io_in0_sign;
    assign sel_mag  = grant ? io_in1_mag  : io_in0_mag;
    assign twos_d   = sel_sign ? (~{1'b0, sel_mag} + 1'b1) : {1'b0, sel_mag};

`ifdef SM_CONV_ARB_NEGZERO_EN
    logic negzero_q;
    assign io_out_negzero = negzero_q;
`endif

    // Reset dominates; a simultaneous drain and accept simply overwrites the held result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            last_q  <= 1'b1;
            twos_q  <= '0;
            src_q   <= 1'b0;
`ifdef SM_CONV_ARB_NEGZERO_EN
            negzero_q <= 1'b0;
`endif
        end else if (accept) begin
            state_q <= ST_FULL;
            last_q  <= grant;
            twos_q  <= twos_d;
            src_q   <= grant;
`ifdef SM_CONV_ARB_NEGZERO_EN
            negzero_q <= sel_sign && (sel_mag == '0);
`endif
        end else if ((state_q == ST_FULL) && io_out_ready) begin
            state_q <= ST_EMPTY;
        end
    end

    assign io_out_valid = (state_q == ST_FULL);
    assign io_out_twos  = twos_q;
    assign io_out_src   = src_q;

endmodule

// File: tb/tb_sm_conv_arbiter.sv
// Directed bench for sm_conv_arbiter (WIDTH=8): reset, round-robin ties, backpressure,
// boundary conversions, mid-operation reset and single-requester streaming.
module tb_sm_conv_arbiter;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         in0_valid, in0_ready, in0_sign;
    logic [W-1:0] in0_mag;
    logic         in1_valid, in1_ready, in1_sign;
    logic [W-1:0] in1_mag;
    logic         out_valid, out_ready, out_src;
    logic [W:0]   out_twos;
`ifdef SM_CONV_ARB_NEGZERO_EN
    logic         out_negzero;
`endif

    int vectors;
    int miscompares;

    sm_conv_arbiter #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in0_valid (in0_valid),
        .io_in0_ready (in0_ready),
        .io_in0_sign  (in0_sign),
        .io_in0_mag   (in0_mag),
        .io_in1_valid (in1_valid),
        .io_in1_ready (in1_ready),
        .io_in1_sign  (in1_sign),
        .io_in1_mag   (in1_mag),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_twos  (out_twos),
`ifdef SM_CONV_ARB_NEGZERO_EN
        .io_out_negzero (out_negzero),
`endif
        .io_out_src   (out_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [W:0] twos, input logic src);
        chk({tag, "_valid"}, {8'b0, out_valid}, {8'b0, v});
        chk({tag, "_twos"}, out_twos, twos);
        chk({tag, "_src"}, {8'b0, out_src}, {8'b0, src});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, "_rdy0"}, {8'b0, in0_ready}, {8'b0, r0});
        chk({tag, "_rdy1"}, {8'b0, in1_ready}, {8'b0, r1});
    endtask

    logic [W:0]   tie_twos [4];
    logic         tie_src  [4];
    logic         bnd_sign [3];
    logic [W-1:0] bnd_mag  [3];
    logic [W:0]   bnd_twos [3];

    initial begin
        vectors     = 0;
        miscompares = 0;
        tie_twos = '{9'h003, 9'h1FD, 9'h003, 9'h1FD};
        tie_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
        bnd_sign = '{1'b1, 1'b0, 1'b1};
        bnd_mag  = '{8'hFF, 8'hFF, 8'h00};
        bnd_twos = '{9'h101, 9'h0FF, 9'h000};

        reset = 1'b1; out_ready = 1'b1;
        in0_valid = 1'b0; in0_sign = 1'b0; in0_mag = '0;
        in1_valid = 1'b0; in1_sign = 1'b0; in1_mag = '0;

        // Reset then single request
        tick();
        chk_out("reset", 1'b0, 9'h000, 1'b0);
        in0_valid = 1'b1; in0_sign = 1'b1; in0_mag = 8'h05;
        chk_rdy("in_reset", 1'b0, 1'b0);
        tick();
        chk_out("reset2", 1'b0, 9'h000, 1'b0);
        reset = 1'b0;
        chk_rdy("single", 1'b1, 1'b0);
        tick();
        chk_out("single", 1'b1, 9'h1FB, 1'b0);

        // Reset again so the tie sequence starts from last=1
        in0_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("rst_pre_tie", 1'b0, 9'h000, 1'b0);

        // Tie and round-robin
        in0_valid = 1'b1; in0_sign = 1'b0; in0_mag = 8'h03;
        in1_valid = 1'b1; in1_sign = 1'b1; in1_mag = 8'h03;
        for (int k = 0; k < 4; k++) begin
            chk_rdy("tie", ~tie_src[k], tie_src[k]);
            tick();
            chk_out("tie", 1'b1, tie_twos[k], tie_src[k]);
        end

        // Backpressure: load 9'h080 from in0, then stall with both valid
        in1_valid = 1'b0; in0_sign = 1'b0; in0_mag = 8'h80;
        chk_rdy("bp_load", 1'b1, 1'b0);
        tick();
        chk_out("bp_load", 1'b1, 9'h080, 1'b0);
        out_ready = 1'b0;
        in0_mag = 8'h22;
        in1_valid = 1'b1; in1_sign = 1'b0; in1_mag = 8'h11;
        for (int k = 0; k < 4; k++) begin
            chk_rdy("bp_stall", 1'b0, 1'b0);
            tick();
            chk_out("bp_stall", 1'b1, 9'h080, 1'b0);
        end
        out_ready = 1'b1;
        chk_rdy("bp_release", 1'b0, 1'b1);
        tick();
        chk_out("bp_release", 1'b1, 9'h011, 1'b1);

        // Boundary values through in0 only
        in1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in0_sign = bnd_sign[k]; in0_mag = bnd_mag[k];
            chk_rdy("bnd", 1'b1, 1'b0);
            tick();
            chk_out("bnd", 1'b1, bnd_twos[k], 1'b0);
`ifdef SM_CONV_ARB_NEGZERO_EN
            chk("bnd_negzero", {8'b0, out_negzero}, {8'b0, (k == 2)});
`endif
        end

        // Reset mid-operation while full and stalled
        out_ready = 1'b0;
        in0_sign = 1'b0; in0_mag = 8'h21;
        in1_valid = 1'b1; in1_sign = 1'b0; in1_mag = 8'h42;
        tick();
        chk_out("stall_pre_rst", 1'b1, 9'h000, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("mid_rst", 1'b0, 9'h000, 1'b0);
`ifdef SM_CONV_ARB_NEGZERO_EN
        chk("mid_rst_negzero", {8'b0, out_negzero}, 9'h000);
`endif
        out_ready = 1'b1;
        chk_rdy("post_rst_tie", 1'b1, 1'b0);
        tick();
        chk_out("post_rst_tie", 1'b1, 9'h021, 1'b0);

        // Single-requester streaming on in1
        in0_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in1_sign = 1'b0; in1_mag = W'(k);
            chk_rdy("stream", 1'b0, 1'b1);
            tick();
            chk_out("stream", 1'b1, 9'(k), 1'b1);
        end

        // Drain with no new request
        in1_valid = 1'b0;
        tick();
        chk("drain_valid", {8'b0, out_valid}, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
